// File: rtl/mult_booth_pkg.sv
// Shared types and elaboration-time helpers for the pipelined carry-lookahead adder/subtractor.
// The helpers size each pipeline stage's slice and locate its bits in the flat skew registers.
package mult_booth_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Exclusive upper bit index of stage k's slice; the final slice is clipped to dw.
    function automatic int slice_hi(input int dw, input int bw, input int k);
        return ((k + 1) * bw < dw) ? (k + 1) * bw : dw;
    endfunction

    function automatic int slice_width(input int dw, input int bw, input int k);
        return slice_hi(dw, bw, k) - k * bw;
    endfunction

    // After stage k the pipeline holds sum bits [slice_hi-1:0] and operand bits [dw-1:slice_hi];
    // these return where stage k's share starts in the concatenation of all stages.
    function automatic int sum_offset(input int dw, input int bw, input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) begin
            off += slice_hi(dw, bw, j);
        end
        return off;
    endfunction

    function automatic int opd_offset(input int dw, input int bw, input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) begin
            off += dw - slice_hi(dw, bw, j);
        end
        return off;
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational carry-lookahead slice: every internal carry is a flat sum of products of the
// slice's generate/propagate terms and cin, so no carry ripples through the slice.
module cla_block #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // c[i] = (cin & p[0..i-1]) | OR over j<i of (g[j] & p[j+1..i-1])
    always_comb begin
        logic term;
        logic acc;
        // NOTE: combinational temporaries use blocking '=' so each statement sees the value
        // just computed; non-blocking here would read stale values and simulate wrongly.
        c = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            term = cin;
            for (int m = 0; m < i; m++) begin
                term = term & p[m];
            end
            acc = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                acc = acc | term;
            end
            c[i] = acc;
        end
    end

    assign sum      = p ^ c[WIDTH-1:0];
    assign cout     = c[WIDTH];
    assign c_msb_in = c[WIDTH-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one lookahead slice per stage, with operands and
// partial sums skewed so every bit of a transaction reaches the output stage together.
module pipelined_cla_addsub
    import mult_booth_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] iv_a,
    input  logic [DATA_WIDTH-1:0] iv_b,
    input  logic                  i_cin,
    input  logic                  i_sub,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] ov_sum,
    output logic                  o_cout,
    output logic                  o_ovf
);

    localparam int NUM_STAGES = ceil_div(DATA_WIDTH, BLOCK_WIDTH);
    localparam int SUM_BITS   = sum_offset(DATA_WIDTH, BLOCK_WIDTH, NUM_STAGES);
    localparam int OPD_RAW    = opd_offset(DATA_WIDTH, BLOCK_WIDTH, NUM_STAGES);
    localparam int OPD_BITS   = (OPD_RAW > 0) ? OPD_RAW : 1;
    localparam int LAST_SO    = sum_offset(DATA_WIDTH, BLOCK_WIDTH, NUM_STAGES - 1);

    if (DATA_WIDTH < 2 || BLOCK_WIDTH < 1 || BLOCK_WIDTH > DATA_WIDTH) begin : g_bad_params
        $error("pipelined_cla_addsub: illegal DATA_WIDTH/BLOCK_WIDTH combination");
    end

    logic                  en;
    logic                  c0;
    logic [DATA_WIDTH-1:0] b_mod;

    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] carry_q;
    logic [SUM_BITS-1:0]   sum_q;
    logic [OPD_BITS-1:0]   a_q;
    logic [OPD_BITS-1:0]   b_q;
    logic                  ovf_q;

    // The whole pipeline advances together; only a full, unconsumed output stage stalls it.
    assign en      = ~valid_q[NUM_STAGES-1] | i_ready;
    assign o_ready = en;

    // Subtraction is A + ~B + ~borrow, so one adder serves both modes.
    assign b_mod = (op_e'(i_sub) == OP_SUB) ? ~iv_b : iv_b;
    assign c0    = (op_e'(i_sub) == OP_SUB) ? ~i_cin : i_cin;

    if (OPD_RAW == 0) begin : g_no_skew
        logic unused_opd;
        assign a_q        = '0;
        assign b_q        = '0;
        assign unused_opd = ^{a_q, b_q};
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int LO = k * BLOCK_WIDTH;
        localparam int W  = slice_width(DATA_WIDTH, BLOCK_WIDTH, k);
        localparam int HI = LO + W;
        localparam int SO = sum_offset(DATA_WIDTH, BLOCK_WIDTH, k);
        localparam int UW = DATA_WIDTH - HI;
        localparam int UO = opd_offset(DATA_WIDTH, BLOCK_WIDTH, k);

        logic [W-1:0]  a_s;
        logic [W-1:0]  b_s;
        logic [W-1:0]  s_s;
        logic          c_in;
        logic          c_out;
        logic          c_msb;
        logic          v_in;
        logic [HI-1:0] sum_next;

        if (k == 0) begin : g_head
            assign a_s      = iv_a[HI-1:0];
            assign b_s      = b_mod[HI-1:0];
            assign c_in     = c0;
            assign v_in     = i_valid;
            assign sum_next = s_s;
        end else begin : g_body
            localparam int PUO = opd_offset(DATA_WIDTH, BLOCK_WIDTH, k - 1);
            localparam int PSO = sum_offset(DATA_WIDTH, BLOCK_WIDTH, k - 1);
            assign a_s      = a_q[PUO +: W];
            assign b_s      = b_q[PUO +: W];
            assign c_in     = carry_q[k-1];
            assign v_in     = valid_q[k-1];
            assign sum_next = {s_s, sum_q[PSO +: LO]};
        end

        cla_block #(
            .WIDTH(W)
        ) u_cla (
            .a       (a_s),
            .b       (b_s),
            .cin     (c_in),
            .sum     (s_s),
            .cout    (c_out),
            .c_msb_in(c_msb)
        );

        // Data registers load only for valid items, so bubbles leave the last result in place.
        always_ff @(posedge i_clk) begin
            // NOTE: state registers use non-blocking '<=' so every stage samples the values
            // its neighbour held before this edge, which is what makes the shift work.
            if (i_rst) begin
                valid_q[k]      <= 1'b0;
                carry_q[k]      <= 1'b0;
                sum_q[SO +: HI] <= '0;
            end else if (en) begin
                valid_q[k] <= v_in;
                if (v_in) begin
                    carry_q[k]      <= c_out;
                    sum_q[SO +: HI] <= sum_next;
                end
            end
        end

        // Operand bits above this slice wait here for the later stages that consume them.
        if (UW > 0) begin : g_fwd
            logic [UW-1:0] a_up;
            logic [UW-1:0] b_up;

            if (k == 0) begin : g_src_port
                assign a_up = iv_a[DATA_WIDTH-1:HI];
                assign b_up = b_mod[DATA_WIDTH-1:HI];
            end else begin : g_src_reg
                localparam int PUO = opd_offset(DATA_WIDTH, BLOCK_WIDTH, k - 1);
                assign a_up = a_q[PUO + W +: UW];
                assign b_up = b_q[PUO + W +: UW];
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    a_q[UO +: UW] <= '0;
                    b_q[UO +: UW] <= '0;
                end else if (en && v_in) begin
                    a_q[UO +: UW] <= a_up;
                    b_q[UO +: UW] <= b_up;
                end
            end
        end

        if (k == NUM_STAGES - 1) begin : g_ovf
            // Signed overflow: carry into the word's MSB disagrees with the carry out of it.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    ovf_q <= 1'b0;
                end else if (en && v_in) begin
                    ovf_q <= c_msb ^ c_out;
                end
            end
        end else begin : g_mid
            logic unused_c_msb;
            assign unused_c_msb = c_msb;
        end
    end

    assign o_valid = valid_q[NUM_STAGES-1];
    assign ov_sum  = sum_q[LAST_SO +: DATA_WIDTH];
    assign o_cout  = carry_q[NUM_STAGES-1];
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed 16/4 vectors, backpressure and reset sequences,
// plus random streams on 13/4 and 8/8 instances compared with a behavioural model.
module tb_pipelined_cla_addsub;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    int assert_count = 0;
    int fail_count   = 0;
    int sweeps_done  = 0;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    vec_t tbl [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_cla_addsub #(
        .DATA_WIDTH (16),
        .BLOCK_WIDTH(4)
    ) u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(in_valid),
        .o_ready(in_ready),
        .iv_a   (a),
        .iv_b   (b),
        .i_cin  (cin),
        .i_sub  (sub),
        .o_valid(out_valid),
        .i_ready(out_ready),
        .ov_sum (sum),
        .o_cout (cout),
        .o_ovf  (ovf)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Two's-complement reference: overflow from operand/result signs, not from carries.
    function automatic void ref_model(input int dw, input logic [31:0] ra, input logic [31:0] rb,
                                      input logic rcin, input logic rsub,
                                      output logic [31:0] rsum, output logic rcout,
                                      output logic rovf);
        logic [32:0] mask;
        logic [32:0] aa;
        logic [32:0] bb;
        logic [32:0] full;
        mask  = (33'd1 << dw) - 33'd1;
        aa    = {1'b0, ra} & mask;
        bb    = {1'b0, (rsub ? ~rb : rb)} & mask;
        full  = aa + bb + {32'd0, rsub ^ rcin};
        rsum  = full[31:0] & mask[31:0];
        rcout = full[dw];
        rovf  = (aa[dw-1] == bb[dw-1]) && (rsum[dw-1] != aa[dw-1]);
    endfunction

    task automatic apply_single(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
        sub       = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " sum"}, sum, v.sum);
        check({tag, " cout"}, cout, v.cout);
        check({tag, " ovf"}, ovf, v.ovf);
    endtask

    initial begin : main
        int sent;
        int got;

        tbl[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[8]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        tbl[10] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};
        tbl[11] = '{16'hF0F0, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset o_valid", out_valid, 0);
        check("reset ov_sum", sum, 0);
        check("reset o_cout", cout, 0);
        check("reset o_ovf", ovf, 0);
        check("reset o_ready", in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply_single(tbl[i], $sformatf("vec%0d", i));
        end

        // Stream eight vectors back to back with the sink stalled for three cycles.
        @(negedge clk);
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a   = tbl[sent].a;
                b   = tbl[sent].b;
                cin = tbl[sent].cin;
                sub = tbl[sent].sub;
            end
            #1;
            if (!out_ready) begin
                check("bp stall o_ready", in_ready, 0);
                check("bp stall o_valid", out_valid, 1);
                check("bp stall held sum", sum, tbl[got].sum);
            end else if (out_valid) begin
                check($sformatf("bp item%0d sum", got), sum, tbl[got].sum);
                check($sformatf("bp item%0d cout", got), cout, tbl[got].cout);
                check($sformatf("bp item%0d ovf", got), ovf, tbl[got].ovf);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp items delivered", got, 8);
        check("bp items accepted", sent, 8);

        // Reset with three items in flight, the oldest already presented at the output.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            a        = tbl[i].a;
            b        = tbl[i].b;
            cin      = tbl[i].cin;
            sub      = tbl[i].sub;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pre-reset o_valid", out_valid, 1);
        check("pre-reset ov_sum", sum, tbl[0].sum);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("mid-reset o_valid", out_valid, 0);
        check("mid-reset ov_sum", sum, 0);
        check("mid-reset o_cout", cout, 0);
        check("mid-reset o_ovf", ovf, 0);
        check("mid-reset o_ready", in_ready, 1);
        rst       = 1'b0;
        out_ready = 1'b1;
        apply_single(tbl[3], "post-reset");

        for (int t = 0; t < 20000 && sweeps_done < 2; t++) begin
            @(negedge clk);
        end
        check("random sweeps finished", sweeps_done, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    // Random valid/ready streams on a multi-stage uneven split and on a single-stage build.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int DW = (gi == 0) ? 13 : 8;
        localparam int BW = (gi == 0) ? 4 : 8;

        logic          s_rst;
        logic          s_valid;
        logic          s_oready;
        logic          s_cin;
        logic          s_sub;
        logic          s_ovalid;
        logic          s_iready;
        logic          s_cout;
        logic          s_ovf;
        logic [DW-1:0] s_a;
        logic [DW-1:0] s_b;
        logic [DW-1:0] s_sum;

        pipelined_cla_addsub #(
            .DATA_WIDTH (DW),
            .BLOCK_WIDTH(BW)
        ) u_dut (
            .i_clk  (clk),
            .i_rst  (s_rst),
            .i_valid(s_valid),
            .o_ready(s_oready),
            .iv_a   (s_a),
            .iv_b   (s_b),
            .i_cin  (s_cin),
            .i_sub  (s_sub),
            .o_valid(s_ovalid),
            .i_ready(s_iready),
            .ov_sum (s_sum),
            .o_cout (s_cout),
            .o_ovf  (s_ovf)
        );

        initial begin : stim
            exp_t        q[$];
            exp_t        e;
            logic [31:0] r;

            s_rst    = 1'b1;
            s_valid  = 1'b0;
            s_iready = 1'b1;
            s_a      = '0;
            s_b      = '0;
            s_cin    = 1'b0;
            s_sub    = 1'b0;
            repeat (2) @(negedge clk);
            s_rst = 1'b0;

            for (int cyc = 0; cyc < 10000; cyc++) begin
                if (cyc < 9990) begin
                    r        = $urandom;
                    s_a      = r[DW-1:0];
                    r        = $urandom;
                    s_b      = r[DW-1:0];
                    if ($urandom_range(0, 7) == 0) s_a = '1;
                    if ($urandom_range(0, 7) == 0) s_b = '0;
                    s_cin    = 1'($urandom_range(0, 1));
                    s_sub    = 1'($urandom_range(0, 1));
                    s_valid  = ($urandom_range(0, 3) != 0);
                    s_iready = ($urandom_range(0, 3) != 0);
                end else begin
                    s_valid  = 1'b0;
                    s_iready = 1'b1;
                end
                #1;
                if (s_ovalid && s_iready) begin
                    if (q.size() == 0) begin
                        check($sformatf("w%0d unexpected o_valid", DW), s_ovalid, 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("w%0d sum", DW), 32'(s_sum), e.sum);
                        check($sformatf("w%0d cout", DW), s_cout, e.cout);
                        check($sformatf("w%0d ovf", DW), s_ovf, e.ovf);
                    end
                end
                if (s_valid && s_oready) begin
                    ref_model(DW, 32'(s_a), 32'(s_b), s_cin, s_sub, e.sum, e.cout, e.ovf);
                    q.push_back(e);
                end
                @(negedge clk);
            end
            check($sformatf("w%0d items left undelivered", DW), q.size(), 0);
            sweeps_done++;
        end
    end

endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the Booth multiplier datapath and other wide accumulate paths. The operand width is split into BLOCK_WIDTH-bit slices. Each slice is resolved by a combinational lookahead group in its own pipeline stage, and its carry is registered into the next stage. Operands flow with valid/ready handshaking and a global stall. The block adds a subtract mode, a signed-overflow flag and backpressure, none of which the plain combinational adder provides.

## Interface
- DATA_WIDTH, 16, operand/result width; must be ≥ 2.
- BLOCK_WIDTH, 4, slice width per stage; 1 ≤ BLOCK_WIDTH ≤ DATA_WIDTH.
- NUM_STAGES (localparam), ceil(DATA_WIDTH/BLOCK_WIDTH), pipeline depth; the last slice may be narrower.

Ports:
- i_clk  in  1  clock; the block has one clock.
- i_rst  in  1  reset; synchronous and active-high.
- i_valid  in  1  operand valid.
- o_ready  out  1  block accepts operands this cycle.
- iv_a  in  DATA_WIDTH  operand A.
- iv_b  in  DATA_WIDTH  operand B.
- i_cin  in  1  carry-in in add mode; borrow-in in subtract mode.
- i_sub  in  1  0 = A+B+cin; 1 = A−B−cin.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- ov_sum  out  DATA_WIDTH  result, modulo 2^DATA_WIDTH.
- o_cout  out  1  raw carry out of the MSB. In subtract mode this is the inverted borrow.
- o_ovf  out  1  two's-complement overflow.

## Operation
- Pipeline enable: en = ~o_valid | i_ready. o_ready = en, combinational from the output stage.
- Operand transform happens at stage-0 input:
  - b' = i_sub ? ~iv_b : iv_b.
  - c0 = i_sub ? ~i_cin : i_cin.
  - The result therefore is A + b' + c0.
- Stage k (0..NUM_STAGES−1):
  - Computes slice k using p = a^b', g = a&b' and full lookahead over the slice's bits.
  - Carry-in comes from the stage k−1 carry register; stage 0 uses c0.
  - On en, it registers the sum slice, carry-out and valid.
- Skew: unconsumed upper operand slices and already-computed lower sum slices ride along in shift registers. This keeps every result bit of a transaction aligned at the output stage.
- Overflow: o_ovf = carry-into-MSB XOR carry-out-of-MSB, computed in the last stage.
- Transfers:
  - Input is accepted when i_valid & o_ready.
  - Output is consumed when o_valid & i_ready.
  - When en = 0 all stages hold; no bubble is inserted and no data is lost.
  - A bubble (i_valid = 0 with en = 1) propagates as a valid = 0 stage.
  - Bubbles are not compressed: throughput is 1 per cycle when i_ready stays high.
- Reset:
  - All stage valid bits, data, carries and flags clear to 0.
  - Outputs at reset: o_valid = 0, ov_sum = 0, o_cout = 0, o_ovf = 0, o_ready = 1.
  - Reset mid-operation discards every in-flight transaction.
- Width edge cases:
  - DATA_WIDTH % BLOCK_WIDTH ≠ 0: the last slice is DATA_WIDTH − (NUM_STAGES−1)·BLOCK_WIDTH bits.
  - BLOCK_WIDTH = DATA_WIDTH: one stage, latency 1.

## Timing
- Latency is NUM_STAGES cycles from an accepted input to o_valid, provided no stall occurs.
- Each stall cycle adds exactly one cycle of latency to every in-flight item.
- ov_sum, o_cout and o_ovf are registered. They change only on en while o_valid is 1, and are held while o_valid & ~i_ready.
- o_ready is combinational from i_ready and o_valid. There is no combinational path from i_valid to o_valid.
- Critical path: one BLOCK_WIDTH lookahead group plus the carry-register input.

## Structure
- Package mult_booth_pkg:
  - Function ceil_div.
  - Localparam helper for the slice width of stage k.
- Sub-module cla_block:
  - Parametrised combinational lookahead slice, WIDTH parameter.
  - Ports: a, b, cin → sum, cout, c_msb_in (carry into the slice's MSB, used for overflow).
  - One instance per stage, generated inside the top-level.
- Top-level contains:
  - Stage registers.
  - Skew shift registers.
  - Handshake enable.

## Test plan
All scenarios use DATA_WIDTH = 16, BLOCK_WIDTH = 4 unless stated.
- Add, no stall: a = 0x1234, b = 0x4321, cin = 0, sub = 0 → 4 cycles later ov_sum = 0x5555, cout = 0, ovf = 0.
- Full carry ripple across all slices: a = 0xFFFF, b = 0x0000, cin = 1 → ov_sum = 0x0000, cout = 1, ovf = 0.
- Subtract, borrow-in and signed overflow:
  - a = 0x0005, b = 0x0007, cin = 0, sub = 1 → ov_sum = 0xFFFE, cout = 0.
  - a = 0x8000, b = 0x0001, sub = 1 → ov_sum = 0x7FFF, ovf = 1.
- Backpressure: stream 8 back-to-back vectors and hold i_ready = 0 for 3 cycles mid-stream → o_ready = 0 during the stall, outputs held, all 8 results in order with none dropped or duplicated.
- Reset mid-flight: assert i_rst with 3 items in flight → next cycle o_valid = 0 and outputs zero. After release, a new item returns after exactly 4 cycles.
- Parameter sweep: DATA_WIDTH = 13, BLOCK_WIDTH = 4 (4 stages, last slice 1 bit), plus DATA_WIDTH = BLOCK_WIDTH = 8 (latency 1). Run 10k random vectors with random i_valid/i_ready against a behavioural model, checking sum, cout and ovf.
